// File: rtl/rand_pkg.sv
// Shared constants for the LFSR source and random_packer.
// Holds LFSR width and default packer geometry.
package rand_pkg;

  localparam int LFSR_W     = 71;
  localparam int WORD_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/rand_fifo.sv
// Synchronous FIFO holding packed random words.
// Ports: push_i/data_i in, pop_i out, full_o/empty_o/level_o status.
module rand_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A pop frees a slot on the same edge, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is driven from registers only; zero when empty.
  assign data_o = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/random_packer.sv
// Packs one fresh LFSR bit per enabled cycle into WORD_W words, MSB first.
// Ports: en/random in, out_data/out_valid/out_ready stream, level, drop_cnt.
module random_packer
  import rand_pkg::*;
#(
  parameter  int WORD_W = WORD_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int LW     = $clog2(DEPTH) + 1,
  localparam int CNT_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LFSR_W-1:0] random,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     level,
  output logic [15:0]       drop_cnt
);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       drop_cnt_q;
  logic              done, push, pop, full, empty, drop;

  // Only bit 0 is new each clock; the rest is shifted history.
  logic unused_random;
  assign unused_random = ^random[LFSR_W-1:1];

  assign acc_d = {acc_q[WORD_W-2:0], random[0]};
  assign done  = en && (cnt_q == CNT_W'(WORD_W - 1));
  assign push  = done;
  assign pop   = out_valid && out_ready;
  assign drop  = done && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (en) begin
        acc_q <= acc_d;
        cnt_q <= done ? '0 : cnt_q + CNT_W'(1);
      end
      if (drop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  rand_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (acc_d),
    .data_o  (out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign out_valid = !empty;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/random_packer.md
RANDOM_PACKER -- requirements
Module: random_packer

Interface
REQ-001 Parameter WORD_W, default 32: bits per output word; legal range 2..64.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: when high, the current cycle's fresh random bit is consumed.
REQ-006 Port random, input, 71: state of the upstream 71-bit LFSR; only random[0] is used, since it is the only new bit per clock.
REQ-007 Port out_data, output, WORD_W: word at the head of the FIFO.
REQ-008 Port out_valid, output, 1: FIFO not empty.
REQ-009 Port out_ready, input, 1: the consumer accepts the head word.
REQ-010 Port level, output, clog2(DEPTH)+1: number of words currently stored.
REQ-011 Port drop_cnt, output, 16: count of completed words discarded because the FIFO was full; saturates at 16'hFFFF.

Function
REQ-012 On each edge with en=1, acc SHALL update to {acc[WORD_W-2:0], random[0]}, making the first bit collected the MSB, and bit counter cnt SHALL increment.
REQ-013 With en=0, acc and cnt SHALL hold.
REQ-014 When en=1 and cnt=WORD_W-1, the completed word {acc[WORD_W-2:0], random[0]} SHALL be pushed to the FIFO and cnt SHALL wrap to 0.
REQ-015 A pushed word SHALL appear on out_data/out_valid on the cycle after the completing edge: one-cycle latency when the FIFO was empty.
REQ-016 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; the next entry, if any, SHALL be presented on the following cycle.
REQ-017 Words SHALL leave in push order.
REQ-018 Full FIFO, push with no pop: the word SHALL be discarded, drop_cnt SHALL increment (saturating), and FIFO contents SHALL be unchanged.
REQ-019 Full FIFO, push and pop on the same edge: both SHALL occur, with no drop and level unchanged.
REQ-020 Empty FIFO, push with out_ready=1: no pop occurs in that cycle; the word becomes valid next cycle.
REQ-021 out_data SHALL read 0 whenever out_valid=0.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 level SHALL equal pushes minus pops since reset, in the range 0..DEPTH.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While rst_n=0, regardless of clk: acc=0, cnt=0, FIFO empty, out_valid=0, out_data=0, level=0, drop_cnt=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; the first word after release SHALL contain exactly WORD_W bits collected after release.
REQ-027 Deassertion SHALL be sampled only at a rising edge of clk; the first bit SHALL be consumed on the first edge with rst_n=1 and en=1.

Structure
REQ-028 Shared package rand_pkg SHALL hold LFSR_W=71 and the default WORD_W and DEPTH constants, for use by this block and its LFSR source.
REQ-029 The FIFO SHALL be a single sub-module, rand_fifo, with push, pop, full, empty and level ports.
REQ-030 Accumulator, counter and drop counter SHALL live in random_packer.
REQ-031 There SHALL be no combinational path from out_ready to out_valid or out_data.

Verification
REQ-032 Reset, en=1, random[0]=1 for 32 cycles, out_ready=1 -> out_valid rises one cycle after the 32nd edge; out_data=32'hFFFFFFFF; level=1.
REQ-033 random[0] driven 1,0,1,0,... starting with 1 -> out_data=32'hAAAAAAAA.
REQ-034 out_ready=0, 5 words completed -> level=4, drop_cnt=1; then out_ready=1 -> first four words drained in order, out_valid=0 afterwards.
REQ-035 FIFO full, out_ready=1 on the same edge as the 32nd bit -> drop_cnt unchanged, level stays 4, new word appears last.
REQ-036 en low for 10 cycles after 12 bits, then 20 more bits -> exactly one word, equal to the 32 enabled bits in order.
REQ-037 rst_n pulsed low asynchronously after 20 bits -> outputs 0 immediately; the next word is formed from 32 fresh bits only.
